// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus memory-mapped UART TX FIFO, RX read port, stop flag and optional cycle counter
// Optional feature: define MEM_IO_CYCLE_CNT_EN to build the 32-bit cycle counter and its read latch.
// Ports:
//   clk_in, rst_in          clock, asynchronous active-low reset
//   rdy_in                  bus accesses accepted only when high
//   mem_a/mem_wr/mem_dout   CPU byte address, write strobe, write data
//   mem_din                 registered read data, valid one cycle after the access
//   io_buffer_full          registered TX FIFO near-full flag
//   tx_data/tx_valid/tx_ready  UART TX byte stream
//   rx_data/rx_valid/rx_ack    UART RX byte and its pop strobe
//   sim_stop                sticky program-stop flag
module mem_io_responder #(
   parameter int RAM_ADDR_W = 17,
   parameter int TXF_DEPTH  = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ack,
   output logic        sim_stop
);
   localparam int CW = $clog2(TXF_DEPTH);
   logic [7:0] ram [2**RAM_ADDR_W];
   logic [7:0] txf [TXF_DEPTH];
   logic [CW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW:0] fcnt_q, fcnt_d;
   logic [7:0] din_q, din_d, io_rdata;
   logic full_q, full_d, ack_q, ack_d, stop_q, stop_d;
   logic io, rd, wr, push, push_ok, pop;
   logic [15:0] io_off;
   logic unused_a;
   assign unused_a = ^mem_a[31:18];
   assign io       = mem_a[17:16] == 2'b11;
   assign io_off   = mem_a[15:0];
   assign rd       = rdy_in & ~mem_wr;
   assign wr       = rdy_in & mem_wr;
   // stop writes always enqueue a 0x00 marker; plain TX writes of 0x00 are filtered
   assign push     = wr & io & ((io_off == 16'h0000 && mem_dout != 8'h00) || io_off == 16'h0004);
   assign push_ok  = push & (fcnt_q != (CW+1)'(TXF_DEPTH));
   assign tx_valid = fcnt_q != '0;
   assign tx_data  = tx_valid ? txf[rp_q] : 8'h00;
   assign pop      = tx_valid & tx_ready;
   assign mem_din        = din_q;
   assign io_buffer_full = full_q;
   assign rx_ack         = ack_q;
   assign sim_stop       = stop_q;
`ifdef MEM_IO_CYCLE_CNT_EN
   logic [31:0] cyc_q, lat_q, lat_d;
   assign lat_d = (rd && io && io_off == 16'h0004) ? cyc_q : lat_q;
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cyc_q <= '0;
         lat_q <= '0;
      end else begin
         cyc_q <= cyc_q + 32'd1;
         lat_q <= lat_d;
      end
   end
`endif
   always_comb begin
      io_rdata = 8'h00;
      if (io_off == 16'h0000) io_rdata = rx_valid ? rx_data : 8'h00;
`ifdef MEM_IO_CYCLE_CNT_EN
      // byte 0 comes live from the counter so it matches the snapshot taken this cycle
      else if (io_off == 16'h0004) io_rdata = cyc_q[7:0];
      else if (io_off == 16'h0005) io_rdata = lat_q[15:8];
      else if (io_off == 16'h0006) io_rdata = lat_q[23:16];
      else if (io_off == 16'h0007) io_rdata = lat_q[31:24];
`endif
   end
   always_comb begin
      din_d  = rd ? (io ? io_rdata : ram[mem_a[RAM_ADDR_W-1:0]]) : din_q;
      ack_d  = rd & io & (io_off == 16'h0000) & rx_valid;
      stop_d = stop_q | (wr & io & (io_off == 16'h0004));
      wp_d   = wp_q + CW'(push_ok);
      rp_d   = rp_q + CW'(pop);
      fcnt_d = fcnt_q + (CW+1)'(push_ok) - (CW+1)'(pop);
      // raised two entries early so a CPU seeing it a cycle late cannot overflow
      full_d = fcnt_d >= (CW+1)'(TXF_DEPTH - 2);
   end
   always_ff @(posedge clk_in) begin
      if (wr && !io) ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
      if (push_ok) txf[wp_q] <= (io_off == 16'h0004) ? 8'h00 : mem_dout;
   end
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         din_q  <= '0;
         ack_q  <= 1'b0;
         stop_q <= 1'b0;
         full_q <= 1'b0;
         wp_q   <= '0;
         rp_q   <= '0;
         fcnt_q <= '0;
      end else begin
         din_q  <= din_d;
         ack_q  <= ack_d;
         stop_q <= stop_d;
         full_q <= full_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         fcnt_q <= fcnt_d;
      end
   end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: scoreboard bench for mem_io_responder
module tb_mem_io_responder;
   logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b0, mem_wr = 1'b0;
   logic tx_ready = 1'b0, rx_valid = 1'b0;
   logic [31:0] mem_a = '0;
   logic [7:0] mem_dout = '0, rx_data = '0;
   logic [7:0] mem_din, tx_data;
   logic io_buffer_full, tx_valid, rx_ack, sim_stop;
   int errors = 0, checks = 0;
   logic [7:0] exp_rd [$];
   logic [7:0] exp_tx [$];
   logic [7:0] mem_model [logic [31:0]];
   logic [31:0] tb_cyc;

   mem_io_responder dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a), .mem_wr(mem_wr),
      .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ack(rx_ack), .sim_stop(sim_stop)
   );

   always #5 clk_in = ~clk_in;

   // cycles elapsed since reset release, as seen at each access edge
   always @(posedge clk_in or negedge rst_in)
      if (!rst_in) tb_cyc <= '0;
      else tb_cyc <= tb_cyc + 32'd1;

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   task automatic acc(input logic [31:0] a, input logic w, input logic [7:0] d);
      rdy_in = 1'b1; mem_a = a; mem_wr = w; mem_dout = d;
      tick;
      rdy_in = 1'b0; mem_wr = 1'b0;
   endtask

   task automatic test_reset;
      rst_in = 1'b0;
      tick; tick;
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din: got %h want 00", mem_din); end
      checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", io_buffer_full); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL reset_rx_ack: got %b want 0", rx_ack); end
      checks++; if (sim_stop !== 1'b0) begin errors++; $display("FAIL reset_sim_stop: got %b want 0", sim_stop); end
      rst_in = 1'b1;
      tick;
   endtask

   task automatic test_ram;
      logic [31:0] addrs [4];
      logic [7:0] e;
      mem_model[32'h100] = 8'hA5;
      acc(32'h100, 1'b1, 8'hA5);
      acc(32'h100, 1'b0, 8'h00);
      exp_rd.push_back(mem_model[32'h100]);
      e = exp_rd.pop_front();
      checks++; if (mem_din !== e) begin errors++; $display("FAIL ram_rd_after_wr: got %h want %h", mem_din, e); end
      tick;
      checks++; if (mem_din !== e) begin errors++; $display("FAIL ram_hold_idle: got %h want %h", mem_din, e); end
      for (int i = 0; i < 4; i++) begin
         addrs[i] = 32'($urandom_range(0, 17'h1FFFF));
         if (addrs[i] == 32'h100) addrs[i] = 32'h101;
         mem_model[addrs[i]] = 8'($urandom);
         acc(addrs[i], 1'b1, mem_model[addrs[i]]);
      end
      for (int i = 0; i < 4; i++) begin
         acc(addrs[i], 1'b0, 8'h00);
         exp_rd.push_back(mem_model[addrs[i]]);
         e = exp_rd.pop_front();
         checks++; if (mem_din !== e) begin errors++; $display("FAIL ram_rand_rd[%0d] @%h: got %h want %h", i, addrs[i], mem_din, e); end
      end
   endtask

   task automatic test_rdy_low;
      logic [7:0] held, e;
      held = mem_din;
      mem_a = 32'h100; mem_wr = 1'b1; mem_dout = 8'h3C;
      tick;
      mem_wr = 1'b0;
      tick;
      checks++; if (mem_din !== held) begin errors++; $display("FAIL rdy_low_hold: got %h want %h", mem_din, held); end
      acc(32'h100, 1'b0, 8'h00);
      exp_rd.push_back(mem_model[32'h100]);
      e = exp_rd.pop_front();
      checks++; if (mem_din !== e) begin errors++; $display("FAIL rdy_low_no_write: got %h want %h", mem_din, e); end
   endtask

   task automatic test_fifo;
      int cnt = 0;
      logic [7:0] e;
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         acc(32'h30000, 1'b1, 8'h41 + 8'(i));
         if (cnt < 8) begin exp_tx.push_back(8'h41 + 8'(i)); cnt++; end
         checks++; if (io_buffer_full !== (cnt >= 6)) begin errors++; $display("FAIL fifo_full_after_push%0d: got %b want %b", i + 1, io_buffer_full, cnt >= 6); end
      end
      checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL fifo_head: got %h want 41", tx_data); end
      tx_ready = 1'b1;
      for (int k = 0; k < 20 && exp_tx.size() > 0; k++) begin
         if (tx_valid === 1'b1) begin
            e = exp_tx.pop_front();
            checks++; if (tx_data !== e) begin errors++; $display("FAIL fifo_drain: got %h want %h", tx_data, e); end
         end
         tick;
      end
      checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL fifo_drain_timeout: got %0d bytes left want 0", exp_tx.size()); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty: got %b want 0", tx_valid); end
      checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL fifo_full_clear: got %b want 0", io_buffer_full); end
   endtask

   task automatic test_zero_stop;
      tx_ready = 1'b0;
      acc(32'h30000, 1'b1, 8'h00);
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL zero_ignored: got %b want 0", tx_valid); end
      checks++; if (sim_stop !== 1'b0) begin errors++; $display("FAIL stop_early: got %b want 0", sim_stop); end
      acc(32'h30004, 1'b1, 8'h77);
      checks++; if (sim_stop !== 1'b1) begin errors++; $display("FAIL stop_set: got %b want 1", sim_stop); end
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL stop_tx_valid: got %b want 1", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL stop_tx_data: got %h want 00", tx_data); end
      tx_ready = 1'b1;
      tick;
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stop_tx_drain: got %b want 0", tx_valid); end
      checks++; if (sim_stop !== 1'b1) begin errors++; $display("FAIL stop_sticky: got %b want 1", sim_stop); end
      tx_ready = 1'b0;
   endtask

   task automatic test_counter;
      logic [31:0] snap;
      logic [7:0] e;
      acc(32'h100, 1'b0, 8'h00);
      exp_rd.push_back(mem_model[32'h100]);
      e = exp_rd.pop_front();
      checks++; if (mem_din !== e) begin errors++; $display("FAIL cnt_pre_rd: got %h want %h", mem_din, e); end
      snap = tb_cyc;
      for (int b = 0; b < 4; b++) begin
`ifdef MEM_IO_CYCLE_CNT_EN
         exp_rd.push_back(snap[8*b +: 8]);
`else
         exp_rd.push_back(8'h00);
`endif
         acc(32'h30004 + 32'(b), 1'b0, 8'h00);
         e = exp_rd.pop_front();
         checks++; if (mem_din !== e) begin errors++; $display("FAIL cnt_byte%0d (snap %h): got %h want %h", b, snap, mem_din, e); end
      end
   endtask

   task automatic test_rx;
      logic [7:0] e;
      rx_valid = 1'b1; rx_data = 8'h5A;
      acc(32'h30000, 1'b0, 8'h00);
      exp_rd.push_back(8'h5A);
      e = exp_rd.pop_front();
      checks++; if (mem_din !== e) begin errors++; $display("FAIL rx_data: got %h want %h", mem_din, e); end
      checks++; if (rx_ack !== 1'b1) begin errors++; $display("FAIL rx_ack_pulse: got %b want 1", rx_ack); end
      tick;
      checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL rx_ack_single: got %b want 0", rx_ack); end
      rx_valid = 1'b0;
      acc(32'h100, 1'b0, 8'h00);
      acc(32'h30000, 1'b0, 8'h00);
      exp_rd.push_back(8'h00);
      e = exp_rd.pop_front();
      checks++; if (mem_din !== e) begin errors++; $display("FAIL rx_empty_rd: got %h want %h", mem_din, e); end
      checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL rx_no_ack: got %b want 0", rx_ack); end
      acc(32'h100, 1'b0, 8'h00);
      acc(32'h30010, 1'b0, 8'h00);
      exp_rd.push_back(8'h00);
      e = exp_rd.pop_front();
      checks++; if (mem_din !== e) begin errors++; $display("FAIL io_other_rd: got %h want %h", mem_din, e); end
      acc(32'h30008, 1'b1, 8'h99);
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL io_other_wr: got %b want 0", tx_valid); end
   endtask

   task automatic test_mid_reset;
      logic [7:0] e;
      tx_ready = 1'b0;
      acc(32'h100, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) acc(32'h30000, 1'b1, 8'h78 + 8'(i));
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", tx_valid); end
      rdy_in = 1'b1; mem_a = 32'h100; mem_wr = 1'b0;
      #2 rst_in = 1'b0;
      #1;
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL mid_mem_din: got %h want 00", mem_din); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid: got %b want 0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
      checks++; if (sim_stop !== 1'b0) begin errors++; $display("FAIL mid_sim_stop: got %b want 0", sim_stop); end
      rdy_in = 1'b0;
      tick; tick;
      rst_in = 1'b1;
      tick;
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_fifo_empty: got %b want 0", tx_valid); end
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL mid_read_aborted: got %h want 00", mem_din); end
      acc(32'h100, 1'b0, 8'h00);
      exp_rd.push_back(mem_model[32'h100]);
      e = exp_rd.pop_front();
      checks++; if (mem_din !== e) begin errors++; $display("FAIL mid_ram_kept: got %h want %h", mem_din, e); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_ram;
      test_rdy_low;
      test_fifo;
      test_zero_stop;
      test_counter;
      test_rx;
      test_mid_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
